// File: rtl/ram_alu_sequencer.sv
// Execute-stage controller for the 16x4 operand RAM: fetch two operands, apply
// a 2-bit-coded ALU op, and write the result back to the RAM.
module ram_alu_sequencer #(
    parameter int DW = 4,
    parameter int AW = 4
) (
    input  logic          clock,
    input  logic          reset_n,
    input  logic          start,
    input  logic [1:0]    opcode,
    input  logic [AW-1:0] src1,
    input  logic [AW-1:0] src2,
    input  logic [AW-1:0] dst,
    output logic          busy,
    output logic          done,
    output logic [DW-1:0] result,
    output logic          carry,
    output logic          ram_we,
    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_data,
    output logic [AW-1:0] ram_addrop1,
    output logic [AW-1:0] ram_addrop2,
    input  logic [DW-1:0] ram_rdataop1,
    input  logic [DW-1:0] ram_rdataop2
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        READ  = 3'd1,
        EXEC  = 3'd2,
        WRITE = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t        state, state_nxt;
    logic [1:0]    op_q;
    logic [AW-1:0] src1_q, src2_q, dst_q;

    // Returns {carry, result}; carry is the ADD carry-out or the SUB borrow.
    function automatic logic [DW:0] alu(input logic [1:0] op,
                                        input logic [DW-1:0] a,
                                        input logic [DW-1:0] b);
        logic [DW:0] r;
        case (op)
            2'b00:   r = {1'b0, a} + {1'b0, b};
            2'b01:   r = {(a < b), a - b};
            2'b10:   r = {1'b0, a & b};
            default: r = {1'b0, a ^ b};
        endcase
        return r;
    endfunction

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = READ;
            READ:    state_nxt = EXEC;
            EXEC:    state_nxt = WRITE;
            WRITE:   state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Control outputs are registered from the next state so they line up with it.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state  <= IDLE;
            busy   <= 1'b0;
            done   <= 1'b0;
            ram_we <= 1'b0;
            carry  <= 1'b0;
            result <= '0;
            op_q   <= '0;
            src1_q <= '0;
            src2_q <= '0;
            dst_q  <= '0;
        end else begin
            state  <= state_nxt;
            busy   <= (state_nxt != IDLE);
            done   <= (state_nxt == DONE);
            ram_we <= (state_nxt == WRITE);
            if (state == IDLE && start) begin
                op_q   <= opcode;
                src1_q <= src1;
                src2_q <= src2;
                dst_q  <= dst;
            end
            // Registered RAM read data is valid during EXEC.
            if (state == EXEC)
                {carry, result} <= alu(op_q, ram_rdataop1, ram_rdataop2);
        end
    end

    assign ram_addr    = dst_q;
    assign ram_data    = result;
    assign ram_addrop1 = src1_q;
    assign ram_addrop2 = src2_q;

endmodule

// File: tb/tb_ram_alu_sequencer.sv
// Directed bench for ram_alu_sequencer with a behavioural registered-read 16x4 RAM.
module tb_ram_alu_sequencer;

    logic       clock = 1'b0;
    logic       reset_n;
    logic       start;
    logic [1:0] opcode;
    logic [3:0] src1, src2, dst;
    logic       busy, done, carry, ram_we;
    logic [3:0] result, ram_addr, ram_data, ram_addrop1, ram_addrop2;
    logic [3:0] ram_rdataop1, ram_rdataop2;

    logic [3:0] mem [16];
    logic       pre_we;
    logic [3:0] pre_addr, pre_data;

    int checks = 0;
    int errors = 0;

    ram_alu_sequencer #(.DW(4), .AW(4)) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .start        (start),
        .opcode       (opcode),
        .src1         (src1),
        .src2         (src2),
        .dst          (dst),
        .busy         (busy),
        .done         (done),
        .result       (result),
        .carry        (carry),
        .ram_we       (ram_we),
        .ram_addr     (ram_addr),
        .ram_data     (ram_data),
        .ram_addrop1  (ram_addrop1),
        .ram_addrop2  (ram_addrop2),
        .ram_rdataop1 (ram_rdataop1),
        .ram_rdataop2 (ram_rdataop2)
    );

    always #5 clock = ~clock;

    // Registered-read RAM; read ports hold while a write is in progress.
    always @(posedge clock) begin
        if (pre_we)
            mem[pre_addr] <= pre_data;
        else if (ram_we)
            mem[ram_addr] <= ram_data;
        else begin
            ram_rdataop1 <= mem[ram_addrop1];
            ram_rdataop2 <= mem[ram_addrop2];
        end
    end

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic load(input logic [3:0] a, input logic [3:0] d);
        @(negedge clock);
        pre_we = 1'b1; pre_addr = a; pre_data = d;
        @(negedge clock);
        pre_we = 1'b0;
    endtask

    // Issue one instruction and check every cycle until the FSM is back in IDLE.
    task automatic run_op(input string tag, input logic [1:0] op,
                          input logic [3:0] s1, input logic [3:0] s2, input logic [3:0] d,
                          input logic [3:0] er, input logic ec, input bit poke);
        @(negedge clock);
        opcode = op; src1 = s1; src2 = s2; dst = d; start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0; opcode = ~op; src1 = ~s1; src2 = ~s2; dst = ~d;
        chk({tag, ".read.busy"}, int'(busy), 1);
        chk({tag, ".read.we"},   int'(ram_we), 0);
        chk({tag, ".read.a1"},   int'(ram_addrop1), int'(s1));
        chk({tag, ".read.a2"},   int'(ram_addrop2), int'(s2));
        if (poke) begin
            start = 1'b1; opcode = 2'b01; src1 = 4'd4; src2 = 4'd5; dst = 4'd15;
        end
        @(posedge clock); #1;
        start = 1'b0;
        chk({tag, ".exec.we"},   int'(ram_we), 0);
        chk({tag, ".exec.done"}, int'(done), 0);
        @(posedge clock); #1;
        chk({tag, ".wr.we"},     int'(ram_we), 1);
        chk({tag, ".wr.addr"},   int'(ram_addr), int'(d));
        chk({tag, ".wr.data"},   int'(ram_data), int'(er));
        chk({tag, ".wr.carry"},  int'(carry), int'(ec));
        chk({tag, ".wr.done"},   int'(done), 0);
        @(posedge clock); #1;
        chk({tag, ".done.done"}, int'(done), 1);
        chk({tag, ".done.we"},   int'(ram_we), 0);
        chk({tag, ".done.busy"}, int'(busy), 1);
        @(posedge clock); #1;
        chk({tag, ".idle.done"}, int'(done), 0);
        chk({tag, ".idle.busy"}, int'(busy), 0);
        chk({tag, ".idle.we"},   int'(ram_we), 0);
        chk({tag, ".mem"},       int'(mem[d]), int'(er));
    endtask

    initial begin
        int we_cnt, we_cyc0, we_cyc1;
        logic [3:0] we_dat0, we_dat1;
        reset_n = 1'b0; start = 1'b0; opcode = 2'b00;
        src1 = '0; src2 = '0; dst = '0;
        pre_we = 1'b0; pre_addr = '0; pre_data = '0;
        for (int i = 0; i < 16; i++) load(4'(i), 4'd0);
        load(4'd1, 4'd5);  load(4'd2, 4'd9);
        load(4'd4, 4'd12); load(4'd5, 4'd7);
        load(4'd6, 4'b1100); load(4'd7, 4'b1010);

        // Reset state
        chk("rst.busy",   int'(busy), 0);
        chk("rst.done",   int'(done), 0);
        chk("rst.we",     int'(ram_we), 0);
        chk("rst.carry",  int'(carry), 0);
        chk("rst.result", int'(result), 0);
        chk("rst.data",   int'(ram_data), 0);
        chk("rst.addr",   int'(ram_addr), 0);
        chk("rst.a1",     int'(ram_addrop1), 0);
        chk("rst.a2",     int'(ram_addrop2), 0);
        @(negedge clock);
        reset_n = 1'b1;
        @(posedge clock); #1;
        chk("idle.nostart", int'(busy), 0);

        run_op("add",     2'b00, 4'd1, 4'd2, 4'd3,  4'd14, 1'b0, 1'b0);
        run_op("addovf",  2'b00, 4'd4, 4'd5, 4'd10, 4'd3,  1'b1, 1'b0);
        run_op("subbor",  2'b01, 4'd5, 4'd4, 4'd11, 4'd11, 1'b1, 1'b0);
        run_op("sub",     2'b01, 4'd4, 4'd5, 4'd12, 4'd5,  1'b0, 1'b0);
        run_op("xoralias",2'b11, 4'd6, 4'd7, 4'd6,  4'b0110, 1'b0, 1'b0);
        run_op("andsame", 2'b10, 4'd7, 4'd7, 4'd13, 4'b1010, 1'b0, 1'b0);
        run_op("busyign", 2'b00, 4'd1, 4'd2, 4'd14, 4'd14, 1'b0, 1'b1);
        chk("busyign.nowrite", int'(mem[15]), 0);
        chk("busyign.result",  int'(result), 14);

        // Back-to-back with start held: second op reads the first op's dst
        we_cnt = 0; we_cyc0 = 0; we_cyc1 = 0; we_dat0 = '0; we_dat1 = '0;
        @(negedge clock);
        opcode = 2'b00; src1 = 4'd1; src2 = 4'd2; dst = 4'd8; start = 1'b1;
        @(posedge clock); #1;
        opcode = 2'b00; src1 = 4'd8; src2 = 4'd1; dst = 4'd9;
        for (int c = 1; c <= 14; c++) begin
            if (c > 1) begin
                @(posedge clock); #1;
            end
            if (ram_we) begin
                if (we_cnt == 0) begin we_cyc0 = c; we_dat0 = ram_data; end
                else begin we_cyc1 = c; we_dat1 = ram_data; end
                we_cnt++;
            end
            if (c == 6) start = 1'b0;
        end
        chk("b2b.wecount", we_cnt, 2);
        chk("b2b.we0cyc",  we_cyc0, 3);
        chk("b2b.we1cyc",  we_cyc1, 8);
        chk("b2b.data0",   int'(we_dat0), 14);
        chk("b2b.data1",   int'(we_dat1), 3);
        chk("b2b.mem8",    int'(mem[8]), 14);
        chk("b2b.mem9",    int'(mem[9]), 3);
        chk("b2b.busy",    int'(busy), 0);

        // Reset asserted during EXEC abandons the op
        @(negedge clock);
        opcode = 2'b00; src1 = 4'd4; src2 = 4'd5; dst = 4'd0; start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        @(posedge clock); #1;
        reset_n = 1'b0;
        #1;
        chk("rstx.busy", int'(busy), 0);
        chk("rstx.we",   int'(ram_we), 0);
        @(posedge clock); #1;
        reset_n = 1'b1;
        we_cnt = 0;
        for (int c = 0; c < 6; c++) begin
            @(posedge clock); #1;
            if (ram_we) we_cnt++;
        end
        chk("rstx.nowe",  we_cnt, 0);
        chk("rstx.idle",  int'(busy), 0);
        chk("rstx.mem0",  int'(mem[0]), 0);
        run_op("afterrst", 2'b00, 4'd1, 4'd2, 4'd0, 4'd14, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
